fifo_pkt_framer: RTL
====================

Name: fifo_pkt_framer

Overview:
- Sits directly downstream of the FWFT output side of the team's sync FIFO (same-width or width-converting variant). Pops words from it and emits them as fixed-length packets on a valid/ready stream.
- Each packet is an optional header word followed by pkt_len payload words, with first/last markers.
- Output is fully registered, so the FIFO read side is decoupled from downstream timing.

Parameters:
DATA_WIDTH, 32, width of FIFO words and output data; must be > LEN_WIDTH
LEN_WIDTH, 8, width of pkt_len; max payload 2**LEN_WIDTH-1 words
HDR_EN, 1, 1 = prepend header word per packet; 0 = payload only

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
fifo_dout  in  DATA_WIDTH  FWFT FIFO head word, valid when fifo_empty=0
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  pop FIFO head this cycle (combinational)
pkt_len  in  LEN_WIDTH  payload words per packet, sampled at packet start
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts word
m_data  out  DATA_WIDTH  output word
m_first  out  1  first word of packet (header if HDR_EN, else first payload)
m_last  out  1  last payload word of packet
pkt_cnt  out  16  count of completed packets (last-word handshakes), wraps

Behaviour:
- One clock domain: clk. Reset rst is asynchronous and active-high. All state clears on rst assert.
- Reset values: m_valid=0, m_data=0, m_first=0, m_last=0, pkt_cnt=0, seq=0, state=IDLE; fifo_rd_en=0 while in reset.
- Output register: ld = ~m_valid | m_ready. The register loads only when ld=1.
- Once m_valid=1, m_data, m_first and m_last hold stable until m_ready=1.
- m_valid clears on a handshake when no new word loads in the same cycle.
- States: IDLE, HDR, DATA.
- IDLE:
  - when fifo_empty=0 and pkt_len!=0: latch len_r=pkt_len, clear word counter; go to HDR (HDR_EN=1) or DATA (HDR_EN=0).
  - pkt_len=0: remain IDLE; nothing popped.
- HDR:
  - when ld: load m_data = {seq[DATA_WIDTH-LEN_WIDTH-1:0], len_r}, m_first=1, m_last=0; seq++; go to DATA.
  - no FIFO pop in this state.
- DATA:
  - fifo_rd_en = ld & ~fifo_empty.
  - On pop: load fifo_dout; m_first=1 only for the first payload word when HDR_EN=0; m_last = (cnt==len_r-1); cnt++.
  - On the pop with m_last=1, go to IDLE; when HDR_EN=0, seq++ here.
- FIFO empty mid-packet: no pop. m_valid drops after the pending word is accepted, creating bubbles. The packet resumes when data returns; no timeout.
- pkt_len changes after latch are ignored until the next IDLE exit.
- pkt_cnt increments on m_valid & m_ready & m_last.
- Throughput:
  - 1 payload word/cycle in DATA with m_ready held high.
  - Fixed overhead per packet: 1 IDLE cycle + 1 HDR cycle (HDR_EN=1).
- Latency: FIFO pop to m_valid is 1 cycle (registered).
- m_ready=0 with m_valid=1 blocks loads, so fifo_rd_en=0 (no pop, no loss).
- Reset mid-packet: the packet is abandoned, and words already popped are lost. Remaining FIFO words start a fresh packet with seq=0.
- seq and pkt_cnt wrap silently.

Test Plan:
- Reset then idle: rst pulse, fifo_empty=1 -> m_valid=0, fifo_rd_en=0, pkt_cnt=0 for 20 cycles.
- Basic packet, HDR_EN=1, DATA_WIDTH=32, LEN_WIDTH=8: pkt_len=3, FIFO holds A1,A2,A3, m_ready=1 -> output 0x00000003(first), A1, A2, A3(last); 4 contiguous valid cycles; pkt_cnt=1. A second packet's header is 0x00000103.
- Backpressure: same packet, m_ready low 5 cycles on word A2 -> A2 held stable, fifo_rd_en=0 throughout, no word dropped or duplicated.
- Underflow mid-packet: pkt_len=4, FIFO supplies 2 words, then 10 empty cycles, then 2 words -> m_valid gaps, single m_last on 4th payload word, pkt_cnt +1 once.
- HDR_EN=0 and pkt_len=1: FIFO B1,B2 -> B1 with m_first=1 and m_last=1, then B2 as a separate packet; pkt_cnt=2. pkt_len=0 -> no pops.
- Async reset mid-packet: assert rst during word 2 of 4 -> outputs zero immediately, without waiting for a clk edge. After release, the next header shows seq=0 and pkt_cnt=0.

Source files
------------

// File: rtl/fifo_pkt_framer.sv
// Pops words from an FWFT FIFO and emits them as fixed-length packets
// (optional header + pkt_len payload words) on a fully registered valid/ready stream.
module fifo_pkt_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter bit HDR_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_first,
    output logic                  m_last,
    output logic [15:0]           pkt_cnt
);

    localparam int SEQ_WIDTH = DATA_WIDTH - LEN_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]            r_state;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [SEQ_WIDTH-1:0]  r_seq;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_first;
    logic                  r_last;
    logic [15:0]           r_pkt_cnt;

    logic w_ld;
    logic w_start;
    logic w_hdr_load;
    logic w_pop;
    logic w_last_word;

    assign w_ld        = ~r_valid | m_ready;
    assign w_start     = (r_state == ST_IDLE) & ~fifo_empty & (pkt_len != '0);
    assign w_hdr_load  = (r_state == ST_HDR) & w_ld;
    // Gated by rst so no pop is requested while the block is held in reset.
    assign w_pop       = (r_state == ST_DATA) & w_ld & ~fifo_empty & ~rst;
    assign w_last_word = (r_cnt == (r_len - LEN_WIDTH'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_seq   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_len   <= pkt_len;
                        r_cnt   <= '0;
                        r_state <= HDR_EN ? ST_HDR : ST_DATA;
                    end
                end
                ST_HDR: begin
                    if (w_hdr_load) begin
                        r_seq   <= r_seq + SEQ_WIDTH'(1);
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_pop) begin
                        r_cnt <= r_cnt + LEN_WIDTH'(1);
                        if (w_last_word) begin
                            r_state <= ST_IDLE;
                            if (!HDR_EN) begin
                                r_seq <= r_seq + SEQ_WIDTH'(1);
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_hdr_load) begin
            r_valid <= 1'b1;
            r_data  <= {r_seq, r_len};
            r_first <= 1'b1;
            r_last  <= 1'b0;
        end else if (w_pop) begin
            r_valid <= 1'b1;
            r_data  <= fifo_dout;
            r_first <= (HDR_EN == 1'b0) && (r_cnt == '0);
            r_last  <= w_last_word;
        end else if (m_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else if (r_valid & m_ready & r_last) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign fifo_rd_en = w_pop;
    assign m_valid    = r_valid;
    assign m_data     = r_data;
    assign m_first    = r_first;
    assign m_last     = r_last;
    assign pkt_cnt    = r_pkt_cnt;

endmodule
